fpu_dispatch: RTL and testbench

Issue-side controller for the single-cycle scalar FPU. It accepts one RV32F instruction at a time with its pre-read operands and decodes it into the FPU's one-hot `sfpu_op`, rounding mode and operand buses. It then captures the FPU's registered result and returns it as an FP or integer writeback, while owning the `fcsr` state (`frm`, accrued `fflags`). It sits between the core's execute stage and the FPU.

---
 rtl/fpu_dispatch_pkg.sv | 74 +++++++
 rtl/fpu_instr_decode.sv | 119 +++++++++++
 rtl/fpu_dispatch.sv | 194 +++++++++++++++++++
 tb/tb_fpu_dispatch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_dispatch_pkg.sv
// Shared decode constants, sfpu_op bit map, CSR map and FSM states for fpu_dispatch.
package fpu_dispatch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned SFPU_OP_W  = 24;
  localparam int unsigned FLAGS_W    = 5;
  localparam int unsigned FRM_W      = 3;
  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [6:0] OPC_FMADD  = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD = 7'b1001111;

  // funct7 values with fmt = S (00) in the low two bits
  localparam logic [6:0] F7_FADD     = 7'b0000000;
  localparam logic [6:0] F7_FSUB     = 7'b0000100;
  localparam logic [6:0] F7_FMUL     = 7'b0001000;
  localparam logic [6:0] F7_FDIV     = 7'b0001100;
  localparam logic [6:0] F7_FSQRT    = 7'b0101100;
  localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
  localparam logic [6:0] F7_FMINMAX  = 7'b0010100;
  localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
  localparam logic [6:0] F7_FCMP     = 7'b1010000;
  localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
  localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
  localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;

  localparam int unsigned OP_FADD     = 0;
  localparam int unsigned OP_FSUB     = 1;
  localparam int unsigned OP_FMUL     = 2;
  localparam int unsigned OP_FDIV     = 3;
  localparam int unsigned OP_FSQRT    = 4;
  localparam int unsigned OP_FMIN     = 5;
  localparam int unsigned OP_FMAX     = 6;
  localparam int unsigned OP_FMV_X_W  = 7;
  localparam int unsigned OP_FMV_W_X  = 8;
  localparam int unsigned OP_FEQ      = 9;
  localparam int unsigned OP_FLT      = 10;
  localparam int unsigned OP_FLE      = 11;
  localparam int unsigned OP_FMADD    = 12;
  localparam int unsigned OP_FMSUB    = 13;
  localparam int unsigned OP_FCVT_W_S = 14;
  localparam int unsigned OP_FCVT_S_W = 15;
  localparam int unsigned OP_FNMSUB   = 16;
  localparam int unsigned OP_FNMADD   = 17;
  localparam int unsigned OP_FSGNJ    = 18;
  localparam int unsigned OP_FSGNJN   = 19;
  localparam int unsigned OP_FSGNJX   = 20;
  localparam int unsigned OP_FCLASS   = 21;
  localparam int unsigned OP_UNSIGNED = 22;
  localparam int unsigned OP_SIGNED   = 23;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  localparam logic [2:0] SEL_FPU = 3'b010;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] c;
    logic [XLEN-1:0] int_op;
  } fpu_operands_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_instr_decode.sv
// Combinational RV32F decoder: one-hot sfpu_op, resolved rounding mode, writeback target, illegal.
// FPU_DIVSQRT_EN enables FDIV/FSQRT; otherwise they decode as illegal.
module fpu_instr_decode
  import fpu_dispatch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [2:0]  frm,
  output logic [23:0] sfpu_op,
  output logic [2:0]  rm,
  output logic        wb_fp,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs2;
  logic [1:0]  fmt;
  logic [23:0] op;
  logic [2:0]  rm_res;
  logic        uses_rm;
  logic        bad;
  logic        unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs2    = instr[24:20];
  assign fmt    = instr[26:25];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[19:15], instr[11:7]};

  always_comb begin
    op      = '0;
    uses_rm = 1'b0;
    bad     = 1'b0;
    wb_fp   = 1'b1;
    case (opcode)
      OPC_FMADD:  begin op[OP_FMADD]  = 1'b1; uses_rm = 1'b1; end
      OPC_FMSUB:  begin op[OP_FMSUB]  = 1'b1; uses_rm = 1'b1; end
      OPC_FNMSUB: begin op[OP_FNMSUB] = 1'b1; uses_rm = 1'b1; end
      OPC_FNMADD: begin op[OP_FNMADD] = 1'b1; uses_rm = 1'b1; end
      OPC_OP_FP: begin
        case (funct7)
          F7_FADD: begin op[OP_FADD] = 1'b1; uses_rm = 1'b1; end
          F7_FSUB: begin op[OP_FSUB] = 1'b1; uses_rm = 1'b1; end
          F7_FMUL: begin op[OP_FMUL] = 1'b1; uses_rm = 1'b1; end
`ifdef FPU_DIVSQRT_EN
          F7_FDIV:  begin op[OP_FDIV]  = 1'b1; uses_rm = 1'b1; end
          F7_FSQRT: begin op[OP_FSQRT] = 1'b1; uses_rm = 1'b1; end
`else
          F7_FDIV:  bad = 1'b1;
          F7_FSQRT: bad = 1'b1;
`endif
          F7_FSGNJ: begin
            case (funct3)
              3'b000:  op[OP_FSGNJ]  = 1'b1;
              3'b001:  op[OP_FSGNJN] = 1'b1;
              3'b010:  op[OP_FSGNJX] = 1'b1;
              default: bad = 1'b1;
            endcase
          end
          F7_FMINMAX: begin
            case (funct3)
              3'b000:  op[OP_FMIN] = 1'b1;
              3'b001:  op[OP_FMAX] = 1'b1;
              default: bad = 1'b1;
            endcase
          end
          F7_FCMP: begin
            wb_fp = 1'b0;
            case (funct3)
              3'b010:  op[OP_FEQ] = 1'b1;
              3'b001:  op[OP_FLT] = 1'b1;
              3'b000:  op[OP_FLE] = 1'b1;
              default: bad = 1'b1;
            endcase
          end
          F7_FCVT_W_S, F7_FCVT_S_W: begin
            uses_rm = 1'b1;
            wb_fp   = (funct7 == F7_FCVT_S_W);
            if (funct7 == F7_FCVT_S_W) op[OP_FCVT_S_W] = 1'b1;
            else                       op[OP_FCVT_W_S] = 1'b1;
            // rs2 selects signed vs unsigned integer side
            case (rs2)
              5'd0:    op[OP_SIGNED]   = 1'b1;
              5'd1:    op[OP_UNSIGNED] = 1'b1;
              default: bad = 1'b1;
            endcase
          end
          F7_FMV_X_W: begin
            wb_fp = 1'b0;
            case (funct3)
              3'b000:  op[OP_FMV_X_W] = 1'b1;
              3'b001:  op[OP_FCLASS]  = 1'b1;
              default: bad = 1'b1;
            endcase
          end
          F7_FMV_W_X: begin
            if (funct3 == 3'b000) op[OP_FMV_W_X] = 1'b1;
            else                  bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (fmt != 2'b00) bad = 1'b1;

    // dynamic rm resolves through the CSR; reserved encodings are illegal either way
    rm_res = (funct3 == 3'b111) ? frm : funct3;
    if (uses_rm && (funct3 == 3'b101 || funct3 == 3'b110 || rm_res > 3'b100)) bad = 1'b1;

    rm      = uses_rm ? rm_res : 3'b000;
    illegal = bad;
    sfpu_op = bad ? '0 : op;
  end

endmodule

// File: rtl/fpu_dispatch.sv
// Issue-side controller for the scalar FPU: decode, one-cycle issue, result capture, fcsr ownership.
// FPU_DIVSQRT_EN (see fpu_instr_decode) enables FDIV/FSQRT issue.
module fpu_dispatch
  import fpu_dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] fs1,
  input  logic [31:0] fs2,
  input  logic [31:0] fs3,
  input  logic [31:0] rs1_int,
  output logic [31:0] fpu_operand_a,
  output logic [31:0] fpu_operand_b,
  output logic [31:0] fpu_operand_c,
  output logic [31:0] fpu_operand_int,
  output logic [23:0] fpu_sfpu_op,
  output logic [2:0]  fpu_frm,
  output logic [2:0]  fpu_sel,
  input  logic [31:0] fpu_resultant,
  input  logic [31:0] fpu_result_rd,
  input  logic [4:0]  fpu_s_flags,
  input  logic        fpu_exception,
  input  logic        fpu_interrupt,
  output logic        wb_valid,
  output logic        wb_fp,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        fpu_irq,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata
);

  state_e        state_q, state_d;
  logic [23:0]   op_q, op_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    frm_out_q, frm_out_d;
  fpu_operands_t opnd_q, opnd_d;
  logic [4:0]    rd_q, rd_d;
  logic          pend_fp_q, pend_fp_d;
  logic          ready_q, ready_d;
  logic          illegal_q, illegal_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_fp_q, wb_fp_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [2:0]    frm_q, frm_d;
  logic [4:0]    fflags_q, fflags_d;

  logic [23:0]   dec_op;
  logic [2:0]    dec_rm;
  logic          dec_wb_fp;
  logic          dec_illegal;
  logic          unused_inputs;

  assign unused_inputs = ^{fpu_exception, csr_wdata[31:8]};

  fpu_instr_decode u_decode (
    .instr   (instr),
    .frm     (frm_q),
    .sfpu_op (dec_op),
    .rm      (dec_rm),
    .wb_fp   (dec_wb_fp),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sel_q      <= '0;
      frm_out_q  <= '0;
      opnd_q     <= '0;
      rd_q       <= '0;
      pend_fp_q  <= 1'b0;
      ready_q    <= 1'b1;
      illegal_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_fp_q    <= 1'b0;
      wb_rd_q    <= '0;
      frm_q      <= '0;
      fflags_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      frm_out_q  <= frm_out_d;
      opnd_q     <= opnd_d;
      rd_q       <= rd_d;
      pend_fp_q  <= pend_fp_d;
      ready_q    <= ready_d;
      illegal_q  <= illegal_d;
      wb_valid_q <= wb_valid_d;
      wb_fp_q    <= wb_fp_d;
      wb_rd_q    <= wb_rd_d;
      frm_q      <= frm_d;
      fflags_q   <= fflags_d;
    end
  end

  // Issue FSM: accept in IDLE, strobe the FPU in ISSUE, write back in CAPTURE
  always_comb begin
    state_d    = state_q;
    op_d       = '0;
    sel_d      = '0;
    frm_out_d  = frm_out_q;
    opnd_d     = opnd_q;
    rd_d       = rd_q;
    pend_fp_d  = pend_fp_q;
    illegal_d  = 1'b0;
    wb_valid_d = 1'b0;
    wb_fp_d    = 1'b0;
    wb_rd_d    = '0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else begin
            state_d       = ISSUE;
            op_d          = dec_op;
            sel_d         = SEL_FPU;
            frm_out_d     = dec_rm;
            opnd_d.a      = dec_op[OP_FMV_W_X] ? rs1_int : fs1;
            opnd_d.b      = fs2;
            opnd_d.c      = fs3;
            opnd_d.int_op = rs1_int;
            rd_d          = instr[11:7];
            pend_fp_d     = dec_wb_fp;
          end
        end
      end
      ISSUE: begin
        state_d    = CAPTURE;
        wb_valid_d = 1'b1;
        wb_fp_d    = pend_fp_q;
        wb_rd_d    = rd_q;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // fcsr update: CSR write lands first, then the captured FPU flags accrue on top
  always_comb begin
    frm_d    = frm_q;
    fflags_d = fflags_q;
    if (csr_we) begin
      case (csr_addr)
        CSR_FFLAGS: fflags_d = csr_wdata[4:0];
        CSR_FRM:    frm_d    = csr_wdata[2:0];
        CSR_FCSR: begin
          frm_d    = csr_wdata[7:5];
          fflags_d = csr_wdata[4:0];
        end
        default: ;
      endcase
    end
    if (state_q == CAPTURE) fflags_d = fflags_d | fpu_s_flags;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_FFLAGS: csr_rdata = XLEN'(fflags_q);
      CSR_FRM:    csr_rdata = XLEN'(frm_q);
      CSR_FCSR:   csr_rdata = XLEN'({frm_q, fflags_q});
      default:    csr_rdata = '0;
    endcase
  end

  assign instr_ready     = ready_q;
  assign fpu_sfpu_op     = op_q;
  assign fpu_sel         = sel_q;
  assign fpu_frm         = frm_out_q;
  assign fpu_operand_a   = opnd_q.a;
  assign fpu_operand_b   = opnd_q.b;
  assign fpu_operand_c   = opnd_q.c;
  assign fpu_operand_int = opnd_q.int_op;
  assign illegal         = illegal_q;
  assign wb_valid        = wb_valid_q;
  assign wb_fp           = wb_fp_q;
  assign wb_rd           = wb_rd_q;

  // FPU results are already registered on its side; muxed straight through in CAPTURE
  assign wb_data = wb_valid_q ? (wb_fp_q ? fpu_resultant : fpu_result_rd) : '0;
  assign fpu_irq = (state_q == CAPTURE) & fpu_interrupt;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with an FPU result model and a writeback scoreboard.
module tb_fpu_dispatch;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] fs1 = '0, fs2 = '0, fs3 = '0, rs1_int = '0;
  logic [31:0] fpu_operand_a, fpu_operand_b, fpu_operand_c, fpu_operand_int;
  logic [23:0] fpu_sfpu_op;
  logic [2:0]  fpu_frm, fpu_sel;
  logic [31:0] fpu_resultant = '0, fpu_result_rd = '0;
  logic [4:0]  fpu_s_flags = 5'h1f;
  logic        fpu_exception = 1'b0;
  logic        fpu_interrupt = 1'b1;
  logic        wb_valid, wb_fp;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal, fpu_irq;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;

  localparam logic [6:0] OPFP = 7'b1010011;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        irq;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] m_res = '0, m_rd = '0;
  logic [4:0]  m_flags = '0;
  logic        m_irq = 1'b0;
  logic [4:0]  exp_div_flags;

  fpu_dispatch dut (
    .clk(clk), .rst_l(rst_l), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .fs1(fs1), .fs2(fs2), .fs3(fs3), .rs1_int(rs1_int),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_operand_c(fpu_operand_c), .fpu_operand_int(fpu_operand_int),
    .fpu_sfpu_op(fpu_sfpu_op), .fpu_frm(fpu_frm), .fpu_sel(fpu_sel),
    .fpu_resultant(fpu_resultant), .fpu_result_rd(fpu_result_rd), .fpu_s_flags(fpu_s_flags),
    .fpu_exception(fpu_exception), .fpu_interrupt(fpu_interrupt),
    .wb_valid(wb_valid), .wb_fp(wb_fp), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .fpu_irq(fpu_irq),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  // FPU model: registers the bench-chosen result when strobed, drives junk flags/irq otherwise
  always @(posedge clk) begin
    if (fpu_sel == 3'b010) begin
      fpu_resultant <= m_res;
      fpu_result_rd <= m_rd;
      fpu_s_flags   <= m_flags;
      fpu_interrupt <= m_irq;
    end else begin
      fpu_s_flags   <= 5'h1f;
      fpu_interrupt <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every writeback strobe must match the oldest pushed expectation
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_fp", 32'(wb_fp), 32'(mon_e.fp));
        chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_irq", 32'(fpu_irq), 32'(mon_e.irq));
      end
    end
  end

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] expv);
    csr_addr = a;
    @(negedge clk);
    chk(tag, csr_rdata, expv);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] ra,
                        input logic [31:0] res, input logic [31:0] rres, input logic [4:0] fl,
                        input logic irq, input logic [23:0] eop, input logic [2:0] efrm,
                        input logic efp, input logic cwe, input logic [31:0] cwd);
    exp_t e;
    fs1 = $urandom; fs2 = $urandom; fs3 = $urandom; rs1_int = ra; instr = ins;
    m_res = res; m_rd = rres; m_flags = fl; m_irq = irq;
    chk({tag, "_ready0"}, 32'(instr_ready), 32'd1);
    e.fp = efp; e.rd = ins[11:7]; e.data = efp ? res : rres; e.irq = irq;
    sb.push_back(e);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_sel"}, 32'(fpu_sel), 32'h2);
    chk({tag, "_op"}, 32'(fpu_sfpu_op), 32'(eop));
    chk({tag, "_frm"}, 32'(fpu_frm), 32'(efrm));
    chk({tag, "_opa"}, fpu_operand_a, eop[8] ? ra : fs1);
    chk({tag, "_opb"}, fpu_operand_b, fs2);
    chk({tag, "_opc"}, fpu_operand_c, fs3);
    chk({tag, "_opint"}, fpu_operand_int, ra);
    chk({tag, "_ready1"}, 32'(instr_ready), 32'd0);
    chk({tag, "_irq1"}, 32'(fpu_irq), 32'd0);
    chk({tag, "_wbv1"}, 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    if (cwe) begin csr_we = 1'b1; csr_addr = 12'h003; csr_wdata = cwd; end
    @(negedge clk);
    chk({tag, "_wbv2"}, 32'(wb_valid), 32'd1);
    chk({tag, "_sel2"}, 32'(fpu_sel), 32'd0);
    chk({tag, "_op2"}, 32'(fpu_sfpu_op), 32'd0);
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ins);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ill1"}, 32'(illegal), 32'd1);
    chk({tag, "_sel"}, 32'(fpu_sel), 32'd0);
    chk({tag, "_op"}, 32'(fpu_sfpu_op), 32'd0);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_ill2"}, 32'(illegal), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    csr_addr = 12'h003;
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_sel", 32'(fpu_sel), 32'd0);
    chk("rst_op", 32'(fpu_sfpu_op), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_fcsr", csr_rdata, 32'd0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(posedge clk); #1;

    // FADD from the test plan, static RNE
    run_op("fadd", 32'h00208053, 32'h0, 32'h40400000, 32'h0, 5'b00000, 1'b0,
           24'h000001, 3'b000, 1'b1, 1'b0, 32'h0);
    csr_rd("fadd_fcsr", 12'h003, 32'h0);

    // frm write masks to 3 bits
    csr_wr(12'h002, 32'hFFFF_FFFA);
    csr_rd("frm_rd", 12'h002, 32'h2);
    csr_rd("fcsr_rd", 12'h003, 32'h40);
    csr_rd("bad_addr_rd", 12'h004, 32'h0);

    // dynamic rounding resolves to frm, NX accrues, interrupt passes in CAPTURE
    run_op("fadd_dyn", enc(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5, OPFP), 32'h0,
           32'h12345678, 32'h0, 5'b00001, 1'b1, 24'h000001, 3'b010, 1'b1, 1'b0, 32'h0);
    csr_rd("acc1_fflags", 12'h001, 32'h01);
    run_op("fsub", enc(7'b0000100, 5'd2, 5'd1, 3'b001, 5'd3, OPFP), 32'h0,
           32'hABCD0000, 32'h0, 5'b10000, 1'b0, 24'h000002, 3'b001, 1'b1, 1'b0, 32'h0);
    csr_rd("acc2_fcsr", 12'h003, 32'h51);

    // fcsr write coinciding with CAPTURE: write first, then flags OR in
    run_op("fsub_csr", enc(7'b0000100, 5'd2, 5'd1, 3'b000, 5'd4, OPFP), 32'h0,
           32'h0000BEEF, 32'h0, 5'b10000, 1'b0, 24'h000002, 3'b000, 1'b1, 1'b1, 32'h40);
    csr_rd("cap_wr_fcsr", 12'h003, 32'h50);

    // integer-destination and sub-op-selected instructions
    run_op("fcvt_wu", enc(7'b1100000, 5'd1, 5'd1, 3'b001, 5'd10, OPFP), 32'h0,
           32'hDEADBEEF, 32'hFFFF0001, 5'b00000, 1'b0, 24'h404000, 3'b001, 1'b0, 1'b0, 32'h0);
    run_op("feq", enc(7'b1010000, 5'd2, 5'd1, 3'b010, 5'd7, OPFP), 32'h0,
           32'h11111111, 32'h00000001, 5'b00000, 1'b0, 24'h000200, 3'b000, 1'b0, 1'b0, 32'h0);
    run_op("fmv_w_x", enc(7'b1111000, 5'd0, 5'd1, 3'b000, 5'd8, OPFP), 32'hCAFEF00D,
           32'hCAFEF00D, 32'h0, 5'b00000, 1'b0, 24'h000100, 3'b000, 1'b1, 1'b0, 32'h0);
    run_op("fmadd", enc({5'd3, 2'b00}, 5'd2, 5'd1, 3'b011, 5'd9, 7'b1000011), 32'h0,
           32'h3F000000, 32'h0, 5'b00000, 1'b0, 24'h001000, 3'b011, 1'b1, 1'b0, 32'h0);

`ifdef FPU_DIVSQRT_EN
    run_op("fdiv", enc(7'b0001100, 5'd2, 5'd1, 3'b000, 5'd4, OPFP), 32'h0,
           32'h7F800000, 32'h0, 5'b01000, 1'b0, 24'h000008, 3'b000, 1'b1, 1'b0, 32'h0);
    exp_div_flags = 5'b11000;
`else
    run_illegal("fdiv", enc(7'b0001100, 5'd2, 5'd1, 3'b000, 5'd4, OPFP));
    exp_div_flags = 5'b10000;
`endif
    csr_rd("fdiv_fflags", 12'h001, 32'(exp_div_flags));

    // illegal encodings
    run_illegal("rm101", enc(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd1, OPFP));
    run_illegal("fmt01", enc(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd1, OPFP));
    run_illegal("fcvt_rs2", enc(7'b1100000, 5'd2, 5'd1, 3'b001, 5'd1, OPFP));
    run_illegal("addi", 32'h00000013);
    csr_wr(12'h002, 32'h5);
    csr_rd("frm5_fcsr", 12'h003, 32'({3'b101, exp_div_flags}));
    run_illegal("dyn_frm5", enc(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd1, OPFP));

    // reset asserted mid-ISSUE discards the instruction and clears fcsr
    instr = 32'h00208053;
    m_res = 32'h99999999; m_flags = 5'b00001; m_irq = 1'b0;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rst_pre_sel", 32'(fpu_sel), 32'h2);
    csr_addr = 12'h003;
    #1;
    rst_l = 1'b0;
    #1;
    chk("rst_mid_op", 32'(fpu_sfpu_op), 32'd0);
    chk("rst_mid_sel", 32'(fpu_sel), 32'd0);
    chk("rst_mid_fcsr", csr_rdata, 32'd0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_wb", 32'(wb_valid), 32'd0);
    end
    @(posedge clk); #1;

    // recovery after reset
    run_op("fadd_post", 32'h00208053, 32'h0, 32'h40400000, 32'h0, 5'b00000, 1'b0,
           24'h000001, 3'b000, 1'b1, 1'b0, 32'h0);
    csr_rd("post_fcsr", 12'h003, 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
